// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-RAM port: op codes, timer map and op decode.
// Imported by the MEM/EXE encoder side and by dmem_responder.
package dmem_responder_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;

    localparam logic [31:0] TIMER_BASE_DEF   = 32'h0200_0000;
    localparam logic [31:0] TOFF_MTIMECMP_LO = 32'h0000_4000;
    localparam logic [31:0] TOFF_MTIMECMP_HI = 32'h0000_4004;
    localparam logic [31:0] TOFF_MTIME_LO    = 32'h0000_BFF8;
    localparam logic [31:0] TOFF_MTIME_HI    = 32'h0000_BFFC;

    typedef enum logic [3:0] {
        OP_LB  = 4'b0000,
        OP_LH  = 4'b0001,
        OP_LW  = 4'b0010,
        OP_LBU = 4'b0100,
        OP_LHU = 4'b0101,
        OP_SB  = 4'b1000,
        OP_SH  = 4'b1001,
        OP_SW  = 4'b1010
    } op_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        TREG_CMP_LO  = 2'b00,
        TREG_CMP_HI  = 2'b01,
        TREG_TIME_LO = 2'b10,
        TREG_TIME_HI = 2'b11
    } treg_e;

    typedef struct packed {
        logic  legal;
        logic  store;
        logic  uns;
        size_e size;
    } op_info_t;

    function automatic op_info_t decode_op(logic [3:0] op);
        op_info_t info;
        info.legal = 1'b1;
        info.store = op[3];
        info.uns   = op[2];
        info.size  = SZ_BYTE;
        case (op)
            OP_LB, OP_LBU, OP_SB: info.size = SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: info.size = SZ_HALF;
            OP_LW, OP_SW:         info.size = SZ_WORD;
            default:              info.legal = 1'b0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core <-> data-memory request bus; the core drives it as master.
interface dmem_responder_if;
    import dmem_responder_pkg::*;

    logic                  ram_request;
    logic                  ram_we;
    logic [3:0]            ram_op;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    modport master (
        output ram_request, ram_we, ram_op, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport slave (
        input  ram_request, ram_we, ram_op, ram_addr, ram_wdata,
        output ram_rdata
    );

endinterface

// File: rtl/dmem_responder_mtimer.sv
// Machine timer: prescaler, 64-bit mtime/mtimecmp with word write port,
// and a registered mtime >= mtimecmp interrupt.
module dmem_responder_mtimer
    import dmem_responder_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_i,
    input  treg_e       sel_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        irq_o
);

    localparam int unsigned   CW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] PS_LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] ps_q, ps_d;
    logic [63:0]   mtime_q, mtime_d;
    logic [63:0]   mtimecmp_q, mtimecmp_d;
    logic          irq_q;
    logic          tick;

    // A software write to an mtime half wins over that edge's increment.
    always_comb begin
        tick       = (ps_q == PS_LAST);
        ps_d       = tick ? '0 : ps_q + CW'(1);
        mtime_d    = mtime_q + 64'(tick);
        mtimecmp_d = mtimecmp_q;
        if (we_i) begin
            unique case (sel_i)
                TREG_CMP_LO:  mtimecmp_d[31:0]  = wdata_i;
                TREG_CMP_HI:  mtimecmp_d[63:32] = wdata_i;
                TREG_TIME_LO: mtime_d = {mtime_q[63:32], wdata_i};
                TREG_TIME_HI: mtime_d = {wdata_i, mtime_q[31:0]};
            endcase
        end
    end

    always_comb begin
        unique case (sel_i)
            TREG_CMP_LO:  rdata_o = mtimecmp_q[31:0];
            TREG_CMP_HI:  rdata_o = mtimecmp_q[63:32];
            TREG_TIME_LO: rdata_o = mtime_q[31:0];
            TREG_TIME_HI: rdata_o = mtime_q[63:32];
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ps_q       <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            irq_q      <= 1'b0;
        end else begin
            ps_q       <= ps_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            irq_q      <= (mtime_q >= mtimecmp_q);
        end
    end

    assign irq_o = irq_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave: word RAM with byte-lane stores and extended loads,
// memory-mapped machine timer, and a one-cycle error pulse for bad accesses.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned PRESCALE   = 1,
    parameter logic [31:0] TIMER_BASE = TIMER_BASE_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    dmem_responder_if.slave  bus,
    output logic             err_o,
    output logic             timer_irq_o
);

    localparam int unsigned IW        = $clog2(DEPTH);
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH) * 33'd4;

    logic [31:0]   mem [DEPTH];
    op_info_t      info;
    logic [IW-1:0] idx;
    logic [1:0]    lane;
    logic          in_ram, in_timer, misaligned, mapped;
    logic          err_d, err_q, ok, ram_wr, tmr_we;
    treg_e         tsel;
    logic [31:0]   tmr_rdata, rd_word, shifted, wdata_rep;
    logic [3:0]    be;

    always_comb begin
        info     = decode_op(bus.ram_op);
        lane     = bus.ram_addr[1:0];
        idx      = bus.ram_addr[IW+1:2];
        in_ram   = ({1'b0, bus.ram_addr} < RAM_BYTES);
        in_timer = 1'b1;
        tsel     = TREG_CMP_LO;
        if (bus.ram_addr == TIMER_BASE + TOFF_MTIMECMP_LO)      tsel = TREG_CMP_LO;
        else if (bus.ram_addr == TIMER_BASE + TOFF_MTIMECMP_HI) tsel = TREG_CMP_HI;
        else if (bus.ram_addr == TIMER_BASE + TOFF_MTIME_LO)    tsel = TREG_TIME_LO;
        else if (bus.ram_addr == TIMER_BASE + TOFF_MTIME_HI)    tsel = TREG_TIME_HI;
        else                                                    in_timer = 1'b0;

        case (info.size)
            SZ_HALF: misaligned = lane[0];
            SZ_WORD: misaligned = |lane;
            default: misaligned = 1'b0;
        endcase

        // An op whose load/store class disagrees with ram_we is treated as illegal.
        mapped = in_ram | (in_timer & (info.size == SZ_WORD));
        err_d  = bus.ram_request &
                 (~info.legal | (info.store != bus.ram_we) | misaligned | ~mapped);
        ok     = bus.ram_request & ~err_d;
        ram_wr = ok & bus.ram_we & in_ram;
        tmr_we = ok & bus.ram_we & in_timer;
    end

    always_comb begin
        rd_word = mem[idx];
        shifted = rd_word >> {lane, 3'b000};
        bus.ram_rdata = '0;
        if (ok && !bus.ram_we) begin
            if (in_ram) begin
                case (info.size)
                    SZ_BYTE: bus.ram_rdata = info.uns ? {24'h0, shifted[7:0]}
                                                      : {{24{shifted[7]}}, shifted[7:0]};
                    SZ_HALF: bus.ram_rdata = info.uns ? {16'h0, shifted[15:0]}
                                                      : {{16{shifted[15]}}, shifted[15:0]};
                    default: bus.ram_rdata = rd_word;
                endcase
            end else begin
                bus.ram_rdata = tmr_rdata;
            end
        end
    end

    always_comb begin
        case (info.size)
            SZ_BYTE: begin
                be        = 4'b0001 << lane;
                wdata_rep = {4{bus.ram_wdata[7:0]}};
            end
            SZ_HALF: begin
                be        = lane[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{bus.ram_wdata[15:0]}};
            end
            SZ_WORD: begin
                be        = 4'b1111;
                wdata_rep = bus.ram_wdata;
            end
            default: begin
                be        = '0;
                wdata_rep = bus.ram_wdata;
            end
        endcase
    end

    // Gating with rst_i drops a store that coincides with reset.
    always_ff @(posedge clk_i) begin
        if (ram_wr && rst_i) begin
            if (be[0]) mem[idx][7:0]   <= wdata_rep[7:0];
            if (be[1]) mem[idx][15:8]  <= wdata_rep[15:8];
            if (be[2]) mem[idx][23:16] <= wdata_rep[23:16];
            if (be[3]) mem[idx][31:24] <= wdata_rep[31:24];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err_o = err_q;

    dmem_responder_mtimer #(
        .PRESCALE (PRESCALE)
    ) u_mtimer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (tmr_we),
        .sel_i   (tsel),
        .wdata_i (bus.ram_wdata),
        .rdata_o (tmr_rdata),
        .irq_o   (timer_irq_o)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized
// accesses checked against a byte-addressed memory model.
module tb_dmem_responder;

    localparam logic [31:0] TBASE     = 32'h0200_0000;
    localparam logic [31:0] A_CMP_LO  = TBASE + 32'h4000;
    localparam logic [31:0] A_CMP_HI  = TBASE + 32'h4004;
    localparam logic [31:0] A_TIME_LO = TBASE + 32'hBFF8;
    localparam logic [31:0] A_TIME_HI = TBASE + 32'hBFFC;

    localparam logic [3:0] LB = 4'b0000, LH = 4'b0001, LW = 4'b0010;
    localparam logic [3:0] LBU = 4'b0100, LHU = 4'b0101;
    localparam logic [3:0] SB = 4'b1000, SH = 4'b1001, SW = 4'b1010;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err, irq;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [7:0] mm [256];

    dmem_responder_if bus ();

    dmem_responder #(
        .DEPTH      (1024),
        .PRESCALE   (1),
        .TIMER_BASE (TBASE)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .bus         (bus),
        .err_o       (err),
        .timer_irq_o (irq)
    );

    always #5 clk = ~clk;

    // One access per cycle: drive after negedge, sample load data before the
    // edge, sample the registered error just after it.
    task automatic access(input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd,
                          output logic er);
        @(negedge clk);
        bus.ram_request = 1'b1;
        bus.ram_we      = op[3];
        bus.ram_op      = op;
        bus.ram_addr    = addr;
        bus.ram_wdata   = wd;
        #1 rd = bus.ram_rdata;
        @(posedge clk);
        #1 er = err;
        bus.ram_request = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic er;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", err); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b expected 0", irq); end
        rst_n = 1'b1;
        access(LW, A_TIME_LO, 32'h0, rd, er);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL reset_mtime_lo: got %h expected 0", rd); end
        access(LW, A_CMP_LO, 32'h0, rd, er);
        n_cmp++; if (rd !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL reset_cmp_lo: got %h expected ffffffff", rd); end
        access(LW, A_CMP_HI, 32'h0, rd, er);
        n_cmp++; if (rd !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL reset_cmp_hi: got %h expected ffffffff", rd); end
        access(LW, A_TIME_LO, 32'h0, rd, er);
        n_cmp++; if (rd !== 32'd3) begin n_bad++; $display("FAIL reset_first_ticks: got %h expected 3", rd); end
    endtask

    task automatic test_load_ext();
        logic [31:0] rd, exp_v [8], addrs [8];
        logic [3:0]  ops [8];
        logic er;
        ops    = '{LW, LB, LBU, LH, LHU, LH, LB, LB};
        addrs  = '{32'h10, 32'h13, 32'h13, 32'h10, 32'h12, 32'h12, 32'h10, 32'h11};
        exp_v  = '{32'h8765_4321, 32'hFFFF_FF87, 32'h0000_0087, 32'h0000_4321,
                   32'h0000_8765, 32'hFFFF_8765, 32'h0000_0021, 32'h0000_0043};
        access(SW, 32'h10, 32'h8765_4321, rd, er);
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL sw_err: got %b expected 0", er); end
        for (int i = 0; i < 8; i++) begin
            access(ops[i], addrs[i], 32'h0, rd, er);
            n_cmp++;
            if (rd !== exp_v[i]) begin
                n_bad++; $display("FAIL load_ext[%0d]: got %h expected %h", i, rd, exp_v[i]);
            end
        end
    endtask

    task automatic test_byte_merge();
        logic [31:0] rd;
        logic er;
        access(SW, 32'h20, 32'hFFFF_FFFF, rd, er);
        access(SB, 32'h21, 32'h1234_56AA, rd, er);
        access(SH, 32'h22, 32'hABCD_1234, rd, er);
        access(LW, 32'h20, 32'h0, rd, er);
        n_cmp++; if (rd !== 32'h1234_AAFF) begin n_bad++; $display("FAIL byte_merge: got %h expected 1234aaff", rd); end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd;
        logic er;
        access(SW, 32'h30, 32'h0BAD_F00D, rd, er);
        access(SH, 32'h31, 32'h0000_BEEF, rd, er);
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL sh_mis_err: got %b expected 1", er); end
        @(posedge clk); #1;
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL sh_mis_pulse: got %b expected 0", err); end
        access(LW, 32'h30, 32'h0, rd, er);
        n_cmp++; if (rd !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL sh_mis_nowrite: got %h expected 0badf00d", rd); end
        access(LW, 32'h22, 32'h0, rd, er);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL lw_mis_data: got %h expected 0", rd); end
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL lw_mis_err: got %b expected 1", er); end
        @(posedge clk); #1;
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL lw_mis_pulse: got %b expected 0", err); end
        // top-of-RAM boundary and aliasing just past it
        access(SW, 32'd0, 32'h1111_1111, rd, er);
        access(SW, 32'd4092, 32'hCAFE_BABE, rd, er);
        access(LW, 32'd4092, 32'h0, rd, er);
        n_cmp++; if (rd !== 32'hCAFE_BABE || er !== 1'b0) begin n_bad++; $display("FAIL ram_top: got %h/%b expected cafebabe/0", rd, er); end
        access(SW, 32'd4096, 32'hDEAD_BEEF, rd, er);
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL unmapped_sw_err: got %b expected 1", er); end
        access(LW, 32'd4096, 32'h0, rd, er);
        n_cmp++; if (rd !== 32'h0 || er !== 1'b1) begin n_bad++; $display("FAIL unmapped_lw: got %h/%b expected 0/1", rd, er); end
        access(LW, 32'd0, 32'h0, rd, er);
        n_cmp++; if (rd !== 32'h1111_1111) begin n_bad++; $display("FAIL unmapped_alias: got %h expected 11111111", rd); end
        access(LB, A_CMP_LO, 32'h0, rd, er);
        n_cmp++; if (rd !== 32'h0 || er !== 1'b1) begin n_bad++; $display("FAIL timer_byte: got %h/%b expected 0/1", rd, er); end
        access(4'b0011, 32'h10, 32'h0, rd, er);
        n_cmp++; if (rd !== 32'h0 || er !== 1'b1) begin n_bad++; $display("FAIL illegal_op: got %h/%b expected 0/1", rd, er); end
    endtask

    // Edge k is counted from the edge that loads mtime = 0; mtime after edge k is k,
    // and the irq after edge k reflects mtime(k-1) >= mtimecmp(k-1).
    task automatic test_timer_irq();
        logic [31:0] rd;
        logic er, exp_irq;
        access(SW, A_TIME_HI, 32'h0, rd, er);
        access(SW, A_TIME_LO, 32'h0, rd, er);
        access(SW, A_CMP_HI, 32'h0, rd, er);
        access(SW, A_CMP_LO, 32'd20, rd, er);
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_k2: got %b expected 0", irq); end
        for (int k = 3; k <= 30; k++) begin
            @(posedge clk); #1;
            exp_irq = ((k - 1) >= 20);
            n_cmp++;
            if (irq !== exp_irq) begin n_bad++; $display("FAIL irq_k%0d: got %b expected %b", k, irq, exp_irq); end
        end
        access(SW, A_CMP_LO, 32'hFFFF_FFFF, rd, er);
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_write_edge: got %b expected 1", irq); end
        @(posedge clk); #1;
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_fall: got %b expected 0", irq); end
        access(LW, A_TIME_LO, 32'h0, rd, er);
        n_cmp++; if (rd !== 32'd32) begin n_bad++; $display("FAIL mtime_count: got %h expected 20", rd); end
    endtask

    task automatic test_mtime_carry();
        logic [31:0] rd, exp_v;
        logic [63:0] base [2], val;
        logic er;
        base = '{64'h0000_0000_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF};
        for (int s = 0; s < 2; s++) begin
            access(SW, A_TIME_HI, base[s][63:32], rd, er);
            access(SW, A_TIME_LO, base[s][31:0], rd, er);
            for (int i = 0; i < 4; i++) begin
                val   = base[s] + 64'(i);
                exp_v = (i % 2 == 1) ? val[63:32] : val[31:0];
                access((i % 2 == 1) ? LW : LW, (i % 2 == 1) ? A_TIME_HI : A_TIME_LO, 32'h0, rd, er);
                n_cmp++;
                if (rd !== exp_v) begin n_bad++; $display("FAIL mtime_carry[%0d][%0d]: got %h expected %h", s, i, rd, exp_v); end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, exp_rd, addr, wd;
        logic [3:0]  op;
        logic [3:0]  ops [10];
        logic er, exp_er, legal;
        int sel, nbytes;
        longint v;
        ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW, 4'b0011, 4'b1111};
        for (int w = 0; w < 64; w++) begin
            wd = $urandom;
            access(SW, 32'(w * 4), wd, rd, er);
            for (int b = 0; b < 4; b++) mm[w * 4 + b] = wd[b * 8 +: 8];
            n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL rand_init[%0d]: got %b expected 0", w, er); end
        end
        for (int i = 0; i < 300; i++) begin
            op  = ops[$urandom_range(0, 9)];
            sel = int'($urandom_range(0, 9));
            wd  = $urandom;
            if (sel < 8)       addr = 32'($urandom_range(0, 255));
            else if (sel == 8) addr = 32'h0000_1000 + 32'($urandom_range(0, 255));
            else               addr = (op[1:0] == 2'b10) ? TBASE + 32'h100
                                                         : A_TIME_LO + 32'($urandom_range(0, 3));
            legal  = (op inside {LB, LH, LW, LBU, LHU, SB, SH, SW});
            nbytes = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
            exp_er = !legal || (sel >= 8) || (addr % nbytes != 0);
            exp_rd = 32'h0;
            if (!exp_er && !op[3]) begin
                v = 0;
                for (int b = nbytes - 1; b >= 0; b--) v = v * 256 + longint'(mm[addr + b]);
                if (!op[2] && v >= (longint'(1) << (8 * nbytes - 1))) v -= longint'(1) << (8 * nbytes);
                exp_rd = 32'(v);
            end
            access(op, addr, wd, rd, er);
            if (!exp_er && op[3])
                for (int b = 0; b < nbytes; b++) mm[addr + b] = wd[b * 8 +: 8];
            n_cmp++;
            if (rd !== exp_rd) begin n_bad++; $display("FAIL rand_rdata[%0d] op=%h addr=%h: got %h expected %h", i, op, addr, rd, exp_rd); end
            n_cmp++;
            if (er !== exp_er) begin n_bad++; $display("FAIL rand_err[%0d] op=%h addr=%h: got %b expected %b", i, op, addr, er, exp_er); end
        end
    endtask

    // Leaves reset asserted; test_reset then releases it and checks the reset values.
    task automatic test_reset_midcount();
        logic [31:0] rd;
        logic er;
        access(SW, A_CMP_HI, 32'h0, rd, er);
        access(SW, A_CMP_LO, 32'd5, rd, er);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL midcount_irq_on: got %b expected 1", irq); end
        access(SH, 32'h31, 32'h0, rd, er);
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL midcount_err_on: got %b expected 1", er); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL async_reset_err: got %b expected 0", err); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL async_reset_irq: got %b expected 0", irq); end
    endtask

    initial begin
        bus.ram_request = 1'b0;
        bus.ram_we      = 1'b0;
        bus.ram_op      = 4'h0;
        bus.ram_addr    = 32'h0;
        bus.ram_wdata   = 32'h0;
        test_reset();
        test_load_ext();
        test_byte_merge();
        test_misaligned();
        test_timer_irq();
        test_mtime_carry();
        test_random();
        test_reset_midcount();
        test_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Slave end of the core's data-RAM port (ram_request/ram_we/ram_op/ram_addr/ram_wdata/ram_rdata). It services loads and stores issued by the MEM stage.
- Contains a word-organised data RAM with byte-lane merge on stores and lane-select plus sign/zero extension on loads.
- Contains a memory-mapped 64-bit machine timer (mtime/mtimecmp) that drives the core's timer-interrupt request.
- Sits beside core_top at SoC level; its ram_* ports connect one-to-one to the core's ram_* ports.

Parameters:
- DEPTH, 1024, number of 32-bit RAM words (power of two); RAM occupies byte addresses 0 .. DEPTH*4-1.
- PRESCALE, 1, clk_i cycles per mtime increment (>=1).
- TIMER_BASE, 32'h0200_0000, base of the timer region.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- ram_request_i  in  1  access valid this cycle.
- ram_we_i  in  1  1 = store, 0 = load.
- ram_op_i  in  4  access op code (see Behaviour).
- ram_addr_i  in  ADDR_WIDTH  byte address.
- ram_wdata_i  in  DATA_WIDTH  store data, right-aligned.
- ram_rdata_o  out  DATA_WIDTH  load result, already extended.
- err_o  out  1  registered one-cycle pulse for a misaligned or unmapped access.
- timer_irq_o  out  1  level, high while mtime >= mtimecmp.

Behaviour:
- Op codes:
  - LB = 0000, LH = 0001, LW = 0010, LBU = 0100, LHU = 0101.
  - SB = 1000, SH = 1001, SW = 1010.
  - Any other code is illegal: treat it like an unmapped access.
- Loads:
  - Combinational, zero latency. ram_rdata_o is valid in the same cycle as ram_request_i=1 with ram_we_i=0, because the MEM stage samples it in that cycle.
  - Lane chosen by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
  - ram_rdata_o = 0 when there is no request, on a store, or on an error.
- Stores:
  - Committed on the clk_i edge where ram_request_i = ram_we_i = 1.
  - Byte enables: SB -> 1 lane at addr[1:0]; SH -> 2 lanes at addr[1]; SW -> all 4 lanes.
  - Unselected bytes are preserved.
- Read-during-write to the same word in the same cycle returns the old contents.
- Alignment:
  - LH/LHU/SH require addr[0] = 0; LW/SW require addr[1:0] = 0.
  - A misaligned store writes nothing. A misaligned load returns 0.
  - err_o goes high in the following cycle, for one cycle.
- Address decode:
  - RAM when addr < DEPTH*4.
  - Timer region, word accesses only (LW/SW):
    - TIMER_BASE + 0x4000 = mtimecmp[31:0]
    - TIMER_BASE + 0x4004 = mtimecmp[63:32]
    - TIMER_BASE + 0xBFF8 = mtime[31:0]
    - TIMER_BASE + 0xBFFC = mtime[63:32]
  - Byte or half access to a timer register is an error.
  - Anything else is unmapped: reads 0, writes are ignored, err_o pulses.
- Timer:
  - A prescale counter counts 0 .. PRESCALE-1. On wrap, mtime increments by 1, with full 64-bit carry; 2^64-1 wraps to 0.
  - A software write to a mtime half replaces that half with the written value and suppresses the increment on that edge. The other half is unchanged. The prescale counter is not reset.
  - timer_irq_o is registered: it reflects the compare (mtime >= mtimecmp, unsigned 64-bit) of the previous cycle's register values, so the irq appears 1 cycle after the condition becomes true.
  - Writing mtimecmp above mtime deasserts the irq 1 cycle after the write edge.
- Reset (rst_i = 0, asynchronous):
  - mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, prescale counter = 0.
  - err_o = 0, timer_irq_o = 0.
  - RAM contents are not reset (undefined until written).
  - A store in progress when reset asserts is dropped.
  - After deassertion the first increment occurs PRESCALE cycles later.
- Requests are never stalled; there is no ready handshake, and every request is accepted in the cycle it is presented.

Decomposition:
- The op codes (LB..SW), the timer offsets, and TIMER_BASE go into the shared defines file used by mem/exe, so that encoder and responder agree.
- One sub-module, mtimer: it holds the prescaler, mtime, mtimecmp, the register write port and the irq compare.
- dmem_responder keeps the RAM array, the decode, the lane logic and err_o.

Test Plan:
- SW 0x8765_4321 to addr 0x10, then:
  - LW 0x10 -> 0x8765_4321
  - LB 0x13 -> 0xFFFF_FF87
  - LBU 0x13 -> 0x0000_0087
  - LH 0x10 -> 0x0000_4321
  - LHU 0x12 -> 0x0000_8765
- SW 0xFFFF_FFFF to 0x20, then SB 0xAA to 0x21, then SH 0x1234 to 0x22 -> LW 0x20 = 0x1234_AAFF.
- SH to 0x31 and LW from 0x22 -> no RAM change; err_o = 1 for exactly one cycle after each; ram_rdata_o = 0 for the load.
- PRESCALE = 1: write mtimecmp_hi = 0, then mtimecmp_lo = 20, starting from mtime = 0 -> timer_irq_o rises the cycle after mtime reaches 20. Then write mtimecmp_lo = 0xFFFF_FFFF -> irq falls 1 cycle after the write.
- Write mtime_lo = 0xFFFF_FFFE with hi = 0 -> two increments later, mtime_hi reads 1 and mtime_lo reads 0 (carry).
- Assert rst_i low mid-count with the irq active -> timer_irq_o and err_o are 0 immediately; after release, mtime reads 0 and mtimecmp_lo/hi read 0xFFFF_FFFF.
